alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Upstream feeder for the ALU: holds the 16-entry register file and the PSR flag register.
//  Sequences one instruction at a time: register read, ALU drive, result/flag capture, write-back.
//  Presents ALU operands A, B, Opcode and CarryIn; consumes the ALU result and flags.
//  Sits between instruction issue (start handshake) and the combinational ALU.
// PARAMETERS
//  WIDTH   16  datapath / register width
//  NREGS   16  register-file depth (address width = 4)
//  NFLAGS  5   PSR width, bit order {N,Z,F,L,C}, C = bit 0
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high
//  start          in   1      issue request; sampled only in IDLE
//  opcode         in   8      ALU opcode (values from shared opcode include)
//  rdest          in   4      dest register index, also operand A source
//  rsrc           in   4      operand B register index
//  imm            in   16     immediate operand B
//  use_imm        in   1      1: B = imm, 0: B = R[rsrc]
//  busy           out  1      high in READ/EXEC/WB
//  done           out  1      one-cycle pulse while in WB
//  alu_a          out  16     ALU operand A
//  alu_b          out  16     ALU operand B
//  alu_opcode     out  8      ALU opcode
//  alu_carry_in   out  1      = PSR.C
//  alu_result     in   16     ALU result (combinational from alu_* outputs)
//  alu_flags      in   5      ALU flags {N,Z,F,L,C}
//  psr            out  5      current flag register
//  dbg_raddr      in   4      debug read address
//  dbg_rdata      out  16     R[dbg_raddr], combinational
// BEHAVIOUR
//  Reset (async): state=IDLE, all R[i]=0, psr=0, busy=0, done=0, alu_a/alu_b=0, alu_opcode=0.
//  FSM, registered state: IDLE -> READ -> EXEC -> WB -> IDLE.
//  IDLE: start=1 latches opcode, rdest, rsrc, imm, use_imm; next READ. start=0: stay.
//  READ: alu_a <= R[rdest]; alu_b <= use_imm ? imm_l : R[rsrc]; alu_opcode <= opcode_l.
//  EXEC: ALU settles; at the end of EXEC, res_l <= alu_result and flg_l <= alu_flags.
//  WB: done=1. At the edge ending WB: psr <= flg_l. R[rdest_l] <= res_l unless opcode_l is CMP/CMPI (flags only).
//  Latency: start accepted at edge t; done high in cycle t+3; the written value is visible on dbg_rdata from t+4.
//  Throughput: one instruction per 4 cycles. start is ignored while busy (no queueing), including during WB.
//  Input operands are latched at accept; later input changes do not affect an instruction in flight.
//  alu_carry_in reflects psr at all times. Back-to-back ops chain carry: op n+1 sees op n's C.
//  rdest == rsrc: both operands read the same register's pre-write value.
//  No arithmetic in this block. Widths pass through unmodified; the ALU owns wrap/overflow.
//  Reset mid-operation: immediate IDLE, no register or PSR write, done never pulses for that op.
//  R0 is an ordinary writable register (no hardwired zero).
// STRUCTURE
//  Shared package/include: opcode constants (existing opcode include), state encodings
//    (IDLE=2'd0, READ=2'd1, EXEC=2'd2, WB=2'd3), PSR bit index constants.
//  One sub-module: reg_file_16x16 (async reset, 1 write port, 3 combinational read ports: A, B, dbg).
//  FSM, operand latches and PSR are in the top.
// TESTING
//  Bench: pair this block with the real ALU. Check the clock-by-clock response of busy/done/psr/dbg_rdata.
//  1 Reset: assert reset -> all dbg_rdata reads 0, psr=0, busy=0, done=0.
//  2 ADDI R1, imm=5 (use_imm=1): then ADD R2<-R2+R1 with R2 preloaded to 3 ->
//    done at t+3 each; R1=5, R2=8, Z=0.
//  3 Carry chain: R3=16'hFFFF, ADDI R3, imm=1 -> R3=0, C=1, Z=1.
//    Then ADDC R4(=0)+R0(=0) -> R4=1 (consumes C).
//  4 CMP R5=7 vs R6=9 -> R5 and R6 unchanged; psr.L/N/Z per the ALU's compare rules; done pulses once.
//  5 start held high for 10 cycles -> exactly 3 instructions accepted (t, t+4, t+8); inputs changed mid-op are ignored.
//  6 Async reset asserted in EXEC of ADDI R7, imm=9 -> R7 stays 0, psr=0, no done, FSM in IDLE next cycle.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: opcodes, sequencer states,
// and PSR bit positions.
package alu_operand_sequencer_pkg;

   localparam int SEQ_WIDTH  = 16;
   localparam int SEQ_NREGS  = 16;
   localparam int SEQ_NFLAGS = 5;

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_ADDC = 8'h07;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_CMP  = 8'h0B;
   localparam logic [7:0] OP_MOV  = 8'h0D;
   localparam logic [7:0] OP_ADDI = 8'h50;
   localparam logic [7:0] OP_SUBI = 8'h90;
   localparam logic [7:0] OP_CMPI = 8'hB0;

   // PSR layout {N,Z,F,L,C}
   localparam int PSR_C = 0;
   localparam int PSR_L = 1;
   localparam int PSR_F = 2;
   localparam int PSR_Z = 3;
   localparam int PSR_N = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } seqState_t;

   // Compares only update flags; the destination register is left alone.
   function automatic logic isCompare(input logic [7:0] op);
      return (op == OP_CMP) || (op == OP_CMPI);
   endfunction

endpackage

// File: rtl/alu_operand_sequencer_reg_file_16x16.sv
// General-purpose register file: one synchronous write port, three
// combinational read ports (operand A, operand B, debug).
module reg_file_16x16 #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wrEn,
   input  logic [AW-1:0]    wrAddr,
   input  logic [WIDTH-1:0] wrData,
   input  logic [AW-1:0]    rdAddrA,
   output logic [WIDTH-1:0] rdDataA,
   input  logic [AW-1:0]    rdAddrB,
   output logic [WIDTH-1:0] rdDataB,
   input  logic [AW-1:0]    rdAddrDbg,
   output logic [WIDTH-1:0] rdDataDbg
);

   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs <= '{default: '0};
      end else if (wrEn) begin
         regs[wrAddr] <= wrData;
      end
   end

   assign rdDataA   = regs[rdAddrA];
   assign rdDataB   = regs[rdAddrB];
   assign rdDataDbg = regs[rdAddrDbg];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Feeds the combinational ALU one instruction at a time: read operands,
// drive the ALU, capture result/flags, write back to the register file and PSR.
//
//   state | meaning
//   IDLE  | waiting for start; latches the instruction on accept
//   READ  | register file read, ALU operand registers loaded at end
//   EXEC  | ALU settles; result and flags captured at end
//   WB    | done pulse; register and PSR written at end
module alu_operand_sequencer
   import alu_operand_sequencer_pkg::*;
#(
   parameter int WIDTH  = SEQ_WIDTH,
   parameter int NREGS  = SEQ_NREGS,
   parameter int NFLAGS = SEQ_NFLAGS,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        opcode,
   input  logic [AW-1:0]     rdest,
   input  logic [AW-1:0]     rsrc,
   input  logic [WIDTH-1:0]  imm,
   input  logic              use_imm,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [7:0]        alu_opcode,
   output logic              alu_carry_in,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic [NFLAGS-1:0] alu_flags,
   output logic [NFLAGS-1:0] psr,
   input  logic [AW-1:0]     dbg_raddr,
   output logic [WIDTH-1:0]  dbg_rdata
);

   seqState_t state, nextState;

   logic [7:0]        opcodeL;
   logic [AW-1:0]     rdestL;
   logic [AW-1:0]     rsrcL;
   logic [WIDTH-1:0]  immL;
   logic              useImmL;
   logic [WIDTH-1:0]  resL;
   logic [NFLAGS-1:0] flgL;
   logic [NFLAGS-1:0] psrQ;

   logic              wbEn;
   logic [WIDTH-1:0]  rdDataA;
   logic [WIDTH-1:0]  rdDataB;

   reg_file_16x16 #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
   ) uRegFile (
      .clk       (clk),
      .reset     (reset),
      .wrEn      (wbEn),
      .wrAddr    (rdestL),
      .wrData    (resL),
      .rdAddrA   (rdestL),
      .rdDataA   (rdDataA),
      .rdAddrB   (rsrcL),
      .rdDataB   (rdDataB),
      .rdAddrDbg (dbg_raddr),
      .rdDataDbg (dbg_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = READ;
         READ:    nextState = EXEC;
         EXEC:    nextState = WB;
         WB:      nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      wbEn = 1'b0;
      case (state)
         IDLE:    busy = 1'b0;
         READ,
         EXEC:    busy = 1'b1;
         WB: begin
            busy = 1'b1;
            done = 1'b1;
            wbEn = !isCompare(opcodeL);
         end
         default: busy = 1'b0;
      endcase
   end

   // Instruction latches, ALU operand registers, result capture and PSR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcodeL    <= '0;
         rdestL     <= '0;
         rsrcL      <= '0;
         immL       <= '0;
         useImmL    <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         resL       <= '0;
         flgL       <= '0;
         psrQ       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  opcodeL <= opcode;
                  rdestL  <= rdest;
                  rsrcL   <= rsrc;
                  immL    <= imm;
                  useImmL <= use_imm;
               end
            end
            READ: begin
               alu_a      <= rdDataA;
               alu_b      <= useImmL ? immL : rdDataB;
               alu_opcode <= opcodeL;
            end
            EXEC: begin
               resL <= alu_result;
               flgL <= alu_flags;
            end
            WB: begin
               psrQ <= flgL;
            end
            default: ;
         endcase
      end
   end

   assign psr          = psrQ;
   assign alu_carry_in = psrQ[PSR_C];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a behavioural ALU closes the loop, and a
// register-array model predicts register, PSR and handshake behaviour.
module tb_alu_operand_sequencer;
   import alu_operand_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  opcode;
   logic [3:0]  rdest, rsrc;
   logic [15:0] imm;
   logic        use_imm;
   logic        busy, done;
   logic [15:0] alu_a, alu_b;
   logic [7:0]  alu_opcode;
   logic        alu_carry_in;
   logic [15:0] alu_result;
   logic [4:0]  alu_flags;
   logic [4:0]  psr;
   logic [3:0]  dbg_raddr;
   logic [15:0] dbg_rdata;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] mReg [16];
   logic [4:0]  mPsr;

   always #5 clk = ~clk;

   alu_operand_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .opcode       (opcode),
      .rdest        (rdest),
      .rsrc         (rsrc),
      .imm          (imm),
      .use_imm      (use_imm),
      .busy         (busy),
      .done         (done),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_opcode   (alu_opcode),
      .alu_carry_in (alu_carry_in),
      .alu_result   (alu_result),
      .alu_flags    (alu_flags),
      .psr          (psr),
      .dbg_raddr    (dbg_raddr),
      .dbg_rdata    (dbg_rdata)
   );

   // Behavioural ALU: returns {result, flags{N,Z,F,L,C}}.
   function automatic logic [20:0] aluModel(input logic [7:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
      logic [16:0] s;
      logic [15:0] r;
      logic [4:0]  f;
      s = '0;
      f = '0;
      case (op)
         OP_ADD, OP_ADDI:          s = {1'b0, a} + {1'b0, b};
         OP_ADDC:                  s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         OP_SUB, OP_SUBI,
         OP_CMP, OP_CMPI:          s = {1'b0, a} - {1'b0, b};
         OP_AND:                   s = {1'b0, a & b};
         OP_OR:                    s = {1'b0, a | b};
         OP_XOR:                   s = {1'b0, a ^ b};
         OP_MOV:                   s = {1'b0, b};
         default:                  s = '0;
      endcase
      r = s[15:0];
      if (op == OP_CMP || op == OP_CMPI) begin
         f = {($signed(a) < $signed(b)), (a == b), 1'b0, (a < b), 1'b0};
      end else begin
         f[4] = r[15];
         f[3] = (r == 16'd0);
         if (op == OP_ADD || op == OP_ADDI || op == OP_ADDC) begin
            f[0] = s[16];
            f[2] = (a[15] == b[15]) && (r[15] != a[15]);
         end else if (op == OP_SUB || op == OP_SUBI) begin
            f[0] = s[16];
            f[2] = (a[15] != b[15]) && (r[15] != a[15]);
         end
      end
      return {r, f};
   endfunction

   always_comb {alu_result, alu_flags} = aluModel(alu_opcode, alu_a, alu_b, alu_carry_in);

   function automatic void modelExec(input logic [7:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [15:0] im,
                                     input logic ui);
      logic [20:0] rf;
      rf = aluModel(op, mReg[rd], ui ? im : mReg[rs], mPsr[0]);
      mPsr = rf[4:0];
      if (!(op == OP_CMP || op == OP_CMPI)) mReg[rd] = rf[20:5];
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 16; i++) mReg[i] = '0;
      mPsr = '0;
   endfunction

   // Issue one instruction and check its cycle-by-cycle response; inputs are
   // scrambled while busy to confirm they are latched and start is ignored.
   task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] im, input logic ui);
      logic expDone;
      @(negedge clk);
      start = 1'b1; opcode = op; rdest = rd; rsrc = rs; imm = im; use_imm = ui;
      modelExec(op, rd, rs, im, ui);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         expDone = (k == 2);
         vectors++;
         if (busy !== 1'b1 || done !== expDone) begin
            miscompares++;
            $display("FAIL issue_handshake cyc%0d op=%02h busy=%b done=%b required busy=1 done=%b",
                     k, op, busy, done, expDone);
         end
         start = 1'($urandom); opcode = 8'($urandom); rdest = 4'($urandom);
         rsrc = 4'($urandom); imm = 16'($urandom); use_imm = 1'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL issue_idle op=%02h busy=%b done=%b required 0 0", op, busy, done);
      end
      vectors++;
      if (psr !== mPsr || alu_carry_in !== mPsr[0]) begin
         miscompares++;
         $display("FAIL issue_psr op=%02h psr=%b cin=%b required psr=%b", op, psr, alu_carry_in, mPsr);
      end
      dbg_raddr = rd;
      #1;
      vectors++;
      if (dbg_rdata !== mReg[rd]) begin
         miscompares++;
         $display("FAIL issue_rdest op=%02h R%0d=%h required %h", op, rd, dbg_rdata, mReg[rd]);
      end
      dbg_raddr = rs;
      #1;
      vectors++;
      if (dbg_rdata !== mReg[rs]) begin
         miscompares++;
         $display("FAIL issue_rsrc op=%02h R%0d=%h required %h", op, rs, dbg_rdata, mReg[rs]);
      end
   endtask

   task automatic readReg(input logic [3:0] idx, output logic [15:0] val);
      dbg_raddr = idx;
      #1;
      val = dbg_rdata;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      modelReset();
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         readReg(4'(i), v);
         vectors++;
         if (v !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_reg R%0d=%h required 0000", i, v);
         end
      end
      vectors++;
      if (psr !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || alu_a !== 16'd0 ||
          alu_b !== 16'd0 || alu_opcode !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_outputs psr=%b busy=%b done=%b a=%h b=%h op=%h required all 0",
                  psr, busy, done, alu_a, alu_b, alu_opcode);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_basic();
      logic [15:0] v;
      issue(OP_ADDI, 4'd1, 4'd0, 16'd5, 1'b1);
      issue(OP_ADDI, 4'd2, 4'd0, 16'd3, 1'b1);
      issue(OP_ADD, 4'd2, 4'd1, 16'hDEAD, 1'b0);
      readReg(4'd1, v);
      vectors++;
      if (v !== 16'd5) begin miscompares++; $display("FAIL add_r1 got=%h required 0005", v); end
      readReg(4'd2, v);
      vectors++;
      if (v !== 16'd8 || psr[PSR_Z] !== 1'b0) begin
         miscompares++;
         $display("FAIL add_r2 got=%h Z=%b required 0008 Z=0", v, psr[PSR_Z]);
      end
   endtask

   task automatic test_carry_chain();
      logic [15:0] v;
      issue(OP_ADDI, 4'd3, 4'd0, 16'hFFFF, 1'b1);
      issue(OP_ADDI, 4'd3, 4'd0, 16'd1, 1'b1);
      readReg(4'd3, v);
      vectors++;
      if (v !== 16'd0 || psr[PSR_C] !== 1'b1 || psr[PSR_Z] !== 1'b1) begin
         miscompares++;
         $display("FAIL carry_wrap R3=%h C=%b Z=%b required 0000 C=1 Z=1", v, psr[PSR_C], psr[PSR_Z]);
      end
      issue(OP_ADDC, 4'd4, 4'd0, 16'd0, 1'b0);
      readReg(4'd4, v);
      vectors++;
      if (v !== 16'd1) begin miscompares++; $display("FAIL carry_addc R4=%h required 0001", v); end
   endtask

   task automatic test_compare();
      logic [15:0] v5, v6;
      issue(OP_ADDI, 4'd5, 4'd5, 16'd7, 1'b1);
      issue(OP_ADDI, 4'd6, 4'd6, 16'd9, 1'b1);
      issue(OP_CMP, 4'd5, 4'd6, 16'd0, 1'b0);
      readReg(4'd5, v5);
      readReg(4'd6, v6);
      vectors++;
      if (v5 !== 16'd7 || v6 !== 16'd9) begin
         miscompares++;
         $display("FAIL cmp_regs R5=%h R6=%h required 0007 0009", v5, v6);
      end
      vectors++;
      if (psr[PSR_L] !== 1'b1 || psr[PSR_N] !== 1'b1 || psr[PSR_Z] !== 1'b0) begin
         miscompares++;
         $display("FAIL cmp_flags psr=%b required L=1 N=1 Z=0", psr);
      end
      issue(OP_CMPI, 4'd6, 4'd0, 16'd9, 1'b1);
      vectors++;
      if (psr[PSR_Z] !== 1'b1) begin miscompares++; $display("FAIL cmpi_eq psr=%b required Z=1", psr); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  opList [6];
      logic [15:0] v;
      int          doneCount;
      logic        expDone;
      opList = '{OP_ADD, OP_ADDI, OP_SUB, OP_XOR, OP_ADDC, OP_MOV};
      doneCount = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         start = (k < 10);
         opcode = opList[$urandom_range(0, 5)]; rdest = 4'($urandom); rsrc = 4'($urandom);
         imm = 16'($urandom); use_imm = 1'($urandom);
         if (k == 0 || k == 4 || k == 8) modelExec(opcode, rdest, rsrc, imm, use_imm);
         @(posedge clk);
         #1;
         if (done === 1'b1) doneCount++;
         expDone = (k == 2 || k == 6 || k == 10);
         vectors++;
         if (done !== expDone) begin
            miscompares++;
            $display("FAIL b2b_done cyc%0d done=%b required %b", k, done, expDone);
         end
      end
      start = 1'b0;
      vectors++;
      if (doneCount != 3) begin miscompares++; $display("FAIL b2b_count got=%0d required 3", doneCount); end
      for (int i = 0; i < 16; i++) begin
         readReg(4'(i), v);
         vectors++;
         if (v !== mReg[i]) begin
            miscompares++;
            $display("FAIL b2b_reg R%0d=%h required %h", i, v, mReg[i]);
         end
      end
      vectors++;
      if (psr !== mPsr) begin miscompares++; $display("FAIL b2b_psr psr=%b required %b", psr, mPsr); end
   endtask

   task automatic test_random();
      logic [7:0] opList [10];
      logic [3:0] r;
      opList = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDC, OP_SUB, OP_CMP, OP_MOV, OP_SUBI, OP_CMPI};
      for (int n = 0; n < 40; n++) begin
         r = 4'($urandom);
         issue(opList[$urandom_range(0, 9)], r, (n % 5 == 0) ? r : 4'($urandom),
               16'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] v;
      int          doneSeen;
      @(negedge clk);
      start = 1'b1; opcode = OP_ADDI; rdest = 4'd7; rsrc = 4'd0; imm = 16'd9; use_imm = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      modelReset();
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_async busy=%b done=%b required 0 0", busy, done);
      end
      @(negedge clk);
      reset = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) doneSeen++;
      end
      vectors++;
      if (doneSeen != 0) begin miscompares++; $display("FAIL midreset_idle active=%0d required 0", doneSeen); end
      readReg(4'd7, v);
      vectors++;
      if (v !== 16'd0 || psr !== 5'd0) begin
         miscompares++;
         $display("FAIL midreset_state R7=%h psr=%b required 0000 00000", v, psr);
      end
      issue(OP_ADDI, 4'd7, 4'd0, 16'd9, 1'b1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opcode = '0; rdest = '0; rsrc = '0;
      imm = '0; use_imm = 1'b0; dbg_raddr = '0;
      modelReset();
      test_reset();
      test_add_basic();
      test_carry_chain();
      test_compare();
      test_back_to_back();
      test_reset();
      test_random();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
